// File: rtl/mem_sram_if.sv
// mem_sram_if: request / write-data / read-data bundle between a mem
// master (bridge or testbench) and the mem_sram backing store.
interface mem_sram_if #(
   parameter int MEM_LEN_BITS  = 8,
   parameter int MEM_ADDR_BITS = 32,
   parameter int MEM_DATA_BITS = 64
) ();

   // Handshake semantics:
   //  - mem_req_valid is a one-cycle strobe. It is always accepted, and a
   //    request that arrives while a burst is in flight aborts that burst.
   //  - mem_wr_valid carries one write beat per cycle. It has no ready, so
   //    every beat offered during a write burst is consumed.
   //  - A read beat transfers on a rising edge where mem_rd_valid and
   //    mem_rd_ready are both high. While valid is high and ready is low,
   //    mem_rd_bits is held stable.
   logic                     mem_req_valid;
   logic                     mem_req_opcode;
   logic [MEM_LEN_BITS-1:0]  mem_req_len;
   logic [MEM_ADDR_BITS-1:0] mem_req_addr;
   logic                     mem_wr_valid;
   logic [MEM_DATA_BITS-1:0] mem_wr_bits;
   logic                     mem_rd_valid;
   logic [MEM_DATA_BITS-1:0] mem_rd_bits;
   logic                     mem_rd_ready;

   modport master (
      output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
      output mem_wr_valid, mem_wr_bits, mem_rd_ready,
      input  mem_rd_valid, mem_rd_bits
   );

   modport slave (
      input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
      input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
      output mem_rd_valid, mem_rd_bits
   );

endinterface

// File: rtl/mem_sram.sv
// mem_sram: behavioural burst memory that terminates the mem request/data
// interface on the device side. Bursts carry len+1 beats, and the word index
// wraps modulo the depth. Storage contents are not reset.
// Optional build macro MEM_SRAM_ERR_EN adds a sticky err output. err flags
// requests whose address has byte-offset bits set or bits above the index
// range.
module mem_sram #(
   parameter int MEM_LEN_BITS  = 8,
   parameter int MEM_ADDR_BITS = 32,
   parameter int MEM_DATA_BITS = 64,
   parameter int DEPTH_BITS    = 10
) (
   input  logic       clock,
   input  logic       reset,
   mem_sram_if.slave  mem,
`ifdef MEM_SRAM_ERR_EN
   output logic       err,
`endif
   output logic [1:0] dbg_state,
   output logic       busy
);

   localparam int OFF_BITS = $clog2(MEM_DATA_BITS / 8);
   localparam int WORDS    = 1 << DEPTH_BITS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_FETCH = 2'd1,
      RD_DATA  = 2'd2,
      WRITE    = 2'd3
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [DEPTH_BITS-1:0]    idx;
   logic [DEPTH_BITS-1:0]    idx_inc;
   logic [DEPTH_BITS-1:0]    req_idx;
   logic [MEM_LEN_BITS-1:0]  remaining;
   logic                     rd_valid_q;
   logic [MEM_DATA_BITS-1:0] rd_bits_q;
   logic                     rd_hs;
   logic                     wr_beat;
   logic                     unused_addr;

   logic [MEM_DATA_BITS-1:0] ram [WORDS];

   // Word index of the first beat. Byte-offset bits are dropped and the
   // upper bits are truncated, which makes out-of-range addresses wrap.
   assign req_idx = mem.mem_req_addr[OFF_BITS +: DEPTH_BITS];
   assign idx_inc = idx + DEPTH_BITS'(1);

   // A read beat leaves on valid & ready. A write beat is stored only when
   // no request arrives in the same cycle, because the request takes
   // priority and the beat is dropped.
   assign rd_hs   = (state == RD_DATA) && rd_valid_q && mem.mem_rd_ready;
   assign wr_beat = (state == WRITE) && mem.mem_wr_valid && !mem.mem_req_valid;

   // The whole address feeds the reduction so that bits this build never
   // decodes are not reported as dangling.
   assign unused_addr = ^mem.mem_req_addr;

   assign mem.mem_rd_valid = rd_valid_q;
   assign mem.mem_rd_bits  = rd_bits_q;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A new request restarts from any state.
   always_comb begin
      state_nxt = state;
      if (mem.mem_req_valid) begin
         state_nxt = mem.mem_req_opcode ? WRITE : RD_FETCH;
      end else begin
         case (state)
            IDLE:     state_nxt = IDLE;
            RD_FETCH: state_nxt = RD_DATA;
            RD_DATA:  if (rd_hs && (remaining == '0)) state_nxt = IDLE;
            WRITE:    if (mem.mem_wr_valid && (remaining == '0)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // State-derived outputs.
   always_comb begin
      busy      = (state != IDLE);
      dbg_state = state;
   end

   // Burst bookkeeping and the read-data register. On a read handshake the
   // next word is loaded on the same edge, so beats can go out back to back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx        <= '0;
         remaining  <= '0;
         rd_valid_q <= 1'b0;
         rd_bits_q  <= '0;
      end else if (mem.mem_req_valid) begin
         idx        <= req_idx;
         remaining  <= mem.mem_req_len;
         rd_valid_q <= 1'b0;
      end else begin
         case (state)
            RD_FETCH: begin
               rd_bits_q  <= ram[idx];
               rd_valid_q <= 1'b1;
            end
            RD_DATA: begin
               if (rd_hs) begin
                  if (remaining != '0) begin
                     idx       <= idx_inc;
                     remaining <= remaining - MEM_LEN_BITS'(1);
                     rd_bits_q <= ram[idx_inc];
                  end else begin
                     rd_valid_q <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (mem.mem_wr_valid) begin
                  idx <= idx_inc;
                  if (remaining != '0) begin
                     remaining <= remaining - MEM_LEN_BITS'(1);
                  end
               end
            end
            default: begin
               rd_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage write port. Contents survive reset.
   always_ff @(posedge clock) begin
      if (wr_beat) begin
         ram[idx] <= mem.mem_wr_bits;
      end
   end

`ifdef MEM_SRAM_ERR_EN
   localparam logic [MEM_ADDR_BITS-1:0] OFF_MASK =
      MEM_ADDR_BITS'((1 << OFF_BITS) - 1);

   logic addr_bad;

   assign addr_bad = ((mem.mem_req_addr & OFF_MASK) != '0) ||
                     ((mem.mem_req_addr >> (OFF_BITS + DEPTH_BITS)) != '0);

   // Sticky address error. It can only be cleared by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (mem.mem_req_valid && addr_bad) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
